// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer slice.
// Combinational helpers only, so there is no latency here.
// No flow control lives here.
package game_pkg;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_PLAY  = 2'd1,
        SCR_OVER  = 2'd2
    } screen_t;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int BUG_SIZE = 64;

    // Bug parks in the middle of the reachable area until the first respawn.
    localparam logic [11:0] BUG_X_RST = 12'((SCREEN_W - BUG_SIZE) / 2);
    localparam logic [11:0] BUG_Y_RST = 12'((SCREEN_H - BUG_SIZE) / 2);

    // Fold a 10-bit random value into 0..range-1. A single subtraction is
    // enough because range is always above 512.
    function automatic logic [11:0] wrap_coord(input logic [9:0] r, input int range);
        logic [11:0] r12;
        r12 = {2'b00, r};
        if (r12 < 12'(range)) begin
            return r12;
        end
        return r12 - 12'(range);
    endfunction

endpackage

// File: rtl/game_flow_ctl_if.sv
// Pointer-side inputs and drawing-side outputs of the game sequencer.
// Pure wiring, so there is no latency.
// No backpressure: every signal is a level or a single-cycle pulse.
interface game_flow_ctl_if;
    import game_pkg::*;

    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        hit;
    screen_t     screen;
    logic        game_active;
    logic [6:0]  score;
    logic [6:0]  seconds_left;
    logic [11:0] bug_x;
    logic [11:0] bug_y;
    logic        bug_respawn;

    // Pointer/renderer side drives the inputs and watches the game state.
    modport master (
        output mouse_left, xpos, ypos, hit,
        input  screen, game_active, score, seconds_left, bug_x, bug_y, bug_respawn
    );

    // The sequencer itself.
    modport slave (
        input  mouse_left, xpos, ypos, hit,
        output screen, game_active, score, seconds_left, bug_x, bug_y, bug_respawn
    );

endinterface

// File: rtl/game_flow_ctl_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running every cycle.
// q is the register itself, so a new value appears one cycle after each edge.
// No backpressure: it never stalls.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    // Shift toward the MSB and feed the tap XOR back in at bit 0.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/game_flow_ctl.sv
// Game sequencer: screen FSM, countdown, score and bug respawn placement.
// All outputs are registered and change on the edge that samples their cause.
// No backpressure: inputs are sampled every cycle and hit pulses are never dropped.
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int          CLK_HZ       = 65000000,
    parameter int          GAME_SECONDS = 30,
    parameter int          BTN_XMIN     = 412,
    parameter int          BTN_XMAX     = 611,
    parameter int          BTN_YMIN     = 334,
    parameter int          BTN_YMAX     = 433,
    parameter int          X_RANGE      = SCREEN_W - BUG_SIZE,
    parameter int          Y_RANGE      = SCREEN_H - BUG_SIZE,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic            pclk,
    input  logic            rst,
    game_flow_ctl_if.slave  io
);

    localparam int          PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
    localparam logic [6:0]  SEC_LOAD = 7'(GAME_SECONDS);
    localparam logic [11:0] BX_MIN   = 12'(BTN_XMIN);
    localparam logic [11:0] BX_MAX   = 12'(BTN_XMAX);
    localparam logic [11:0] BY_MIN   = 12'(BTN_YMIN);
    localparam logic [11:0] BY_MAX   = 12'(BTN_YMAX);

    screen_t        state_q;
    screen_t        state_d;
    logic           game_active_q;
    logic           mouse_left_d;
    logic           click;
    logic           in_button;
    logic           tick;
    logic           start_game;
    logic           to_start;
    logic           respawn_req;
    logic [PW-1:0]  presc_q;
    logic [6:0]     score_q;
    logic [6:0]     sec_q;
    logic [11:0]    bug_x_q;
    logic [11:0]    bug_y_q;
    logic           respawn_q;
    logic [15:0]    lfsr_q;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .pclk (pclk),
        .rst  (rst),
        .q    (lfsr_q)
    );

    assign click     = io.mouse_left & ~mouse_left_d;
    assign in_button = (io.xpos >= BX_MIN) && (io.xpos <= BX_MAX) &&
                       (io.ypos >= BY_MIN) && (io.ypos <= BY_MAX);
    // The prescaler only advances in PLAY, so a tick can only happen there.
    assign tick      = (state_q == SCR_PLAY) && (presc_q == PRESC_TC);

    // Next screen plus one-cycle strobes for the datapath registers.
    always_comb begin
        state_d     = state_q;
        start_game  = 1'b0;
        to_start    = 1'b0;
        respawn_req = 1'b0;
        case (state_q)
            SCR_START: begin
                if (click && in_button) begin
                    state_d     = SCR_PLAY;
                    start_game  = 1'b1;
                    respawn_req = 1'b1;
                end
            end
            SCR_PLAY: begin
                // A hit on the final tick still counts; the score path sees it too.
                if (io.hit) begin
                    respawn_req = 1'b1;
                end
                if (tick && (sec_q <= 7'd1)) begin
                    state_d = SCR_OVER;
                end
            end
            SCR_OVER: begin
                if (click) begin
                    state_d  = SCR_START;
                    to_start = 1'b1;
                end
            end
            default: begin
                state_d = SCR_START;
            end
        endcase
    end

    // Screen register, with game_active tracking it from the same next value.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q       <= SCR_START;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            game_active_q <= (state_d == SCR_PLAY);
        end
    end

    // Button history for rising-edge click detection.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            mouse_left_d <= 1'b0;
        end else begin
            mouse_left_d <= io.mouse_left;
        end
    end

    // One-second prescaler, restarted at the beginning of every game.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (start_game) begin
            presc_q <= '0;
        end else if (state_q == SCR_PLAY) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    // Saturating hit counter, cleared when a game starts and held otherwise.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            score_q <= '0;
        end else if (start_game) begin
            score_q <= '0;
        end else if ((state_q == SCR_PLAY) && io.hit && (score_q < SCORE_MAX)) begin
            score_q <= score_q + 7'd1;
        end
    end

    // Countdown: reloaded on entering PLAY or START, decremented on each tick.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            sec_q <= SEC_LOAD;
        end else if (start_game || to_start) begin
            sec_q <= SEC_LOAD;
        end else if (tick) begin
            sec_q <= (sec_q > 7'd1) ? sec_q - 7'd1 : 7'd0;
        end
    end

    // Respawn: new position and pulse land together from the current LFSR value.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            bug_x_q   <= BUG_X_RST;
            bug_y_q   <= BUG_Y_RST;
            respawn_q <= 1'b0;
        end else begin
            respawn_q <= respawn_req;
            if (respawn_req) begin
                bug_x_q <= wrap_coord(lfsr_q[9:0], X_RANGE);
                bug_y_q <= wrap_coord(lfsr_q[15:6], Y_RANGE);
            end
        end
    end

    assign io.screen       = state_q;
    assign io.game_active  = game_active_q;
    assign io.score        = score_q;
    assign io.seconds_left = sec_q;
    assign io.bug_x        = bug_x_q;
    assign io.bug_y        = bug_y_q;
    assign io.bug_respawn  = respawn_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Bench for game_flow_ctl: button-boundary table, hand-written corner sequences,
// and a randomized run, all checked against a cycle model of the game rules.
// A short game second keeps the countdown and the 105-hit burst inside one game.
module tb_game_flow_ctl;
    import game_pkg::*;

    localparam int CLK_HZ  = 100;
    localparam int GS      = 3;
    localparam int X_RANGE = 960;
    localparam int Y_RANGE = 704;

    logic pclk;
    logic rst;

    game_flow_ctl_if bus ();

    game_flow_ctl #(
        .CLK_HZ       (CLK_HZ),
        .GAME_SECONDS (GS)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .io   (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec;
    int n_bad;
    int resp_cnt;
    int bad_range;

    // Reference model state, kept as plain integers.
    int          m_scr;
    int          m_score;
    int          m_sec;
    int          m_presc;
    int          m_bx;
    int          m_by;
    int          m_resp;
    logic [15:0] m_lfsr;
    bit          m_mld;

    typedef struct {
        int x;
        int y;
        bit enter;
    } btn_vec_t;

    btn_vec_t btn_tab [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrapm(input int r, input int range);
        return (r < range) ? r : r - range;
    endfunction

    task automatic model_reset();
        m_scr   = 0;
        m_score = 0;
        m_sec   = GS;
        m_presc = 0;
        m_bx    = 480;
        m_by    = 352;
        m_resp  = 0;
        m_lfsr  = 16'hACE1;
        m_mld   = 1'b0;
    endtask

    // One clock edge of the game rules applied to the inputs held before it.
    task automatic model_edge(input bit ml, input int x, input int y, input bit h);
        bit click;
        bit in_btn;
        bit tick;
        int nscr;
        int resp;
        click  = ml && !m_mld;
        in_btn = (x >= 412) && (x <= 611) && (y >= 334) && (y <= 433);
        nscr   = m_scr;
        resp   = 0;
        if (m_scr == 0) begin
            if (click && in_btn) begin
                nscr    = 1;
                m_score = 0;
                m_sec   = GS;
                m_presc = 0;
                resp    = 1;
            end
        end else if (m_scr == 1) begin
            tick    = (m_presc == CLK_HZ - 1);
            m_presc = tick ? 0 : m_presc + 1;
            if (h) begin
                if (m_score < 99) m_score = m_score + 1;
                resp = 1;
            end
            if (tick) begin
                if (m_sec > 1) begin
                    m_sec = m_sec - 1;
                end else begin
                    m_sec = 0;
                    nscr  = 2;
                end
            end
        end else begin
            if (click) begin
                nscr  = 0;
                m_sec = GS;
            end
        end
        if (resp != 0) begin
            m_bx = wrapm(int'(m_lfsr[9:0]), X_RANGE);
            m_by = wrapm(int'(m_lfsr[15:6]), Y_RANGE);
        end
        m_resp = resp;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_mld  = ml;
        m_scr  = nscr;
    endtask

    task automatic compare_all(input string name);
        logic [63:0] act;
        logic [63:0] exp;
        act = 64'({bus.screen, bus.game_active, bus.score, bus.seconds_left,
                   bus.bug_x, bus.bug_y, bus.bug_respawn});
        exp = 64'({2'(m_scr), (m_scr == 1), 7'(m_score), 7'(m_sec),
                   12'(m_bx), 12'(m_by), 1'(m_resp)});
        check(name, act, exp);
    endtask

    task automatic step(input bit ml, input int x, input int y, input bit h);
        bus.mouse_left = ml;
        bus.xpos       = 12'(x);
        bus.ypos       = 12'(y);
        bus.hit        = h;
        @(posedge pclk);
        model_edge(ml, x, y, h);
        @(negedge pclk);
        compare_all("cycle");
        if (bus.bug_respawn) resp_cnt++;
        if ((bus.bug_x >= 12'(X_RANGE)) || (bus.bug_y >= 12'(Y_RANGE))) bad_range++;
    endtask

    task automatic do_reset();
        bus.mouse_left = 1'b0;
        bus.xpos       = '0;
        bus.ypos       = '0;
        bus.hit        = 1'b0;
        rst = 1'b0;
        @(negedge pclk);
        model_reset();
        compare_all("reset");
        rst = 1'b1;
    endtask

    // Enter PLAY through the button; the mouse is released on the next cycle.
    task automatic enter_play();
        step(1, 500, 400, 0);
        check("enter_screen", 64'(bus.screen), 64'(SCR_PLAY));
        step(0, 500, 400, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        resp_cnt  = 0;
        bad_range = 0;
        rst       = 1'b0;

        btn_tab[0] = '{x: 100, y: 100, enter: 1'b0};
        btn_tab[1] = '{x: 412, y: 433, enter: 1'b1};
        btn_tab[2] = '{x: 412, y: 334, enter: 1'b1};
        btn_tab[3] = '{x: 611, y: 433, enter: 1'b1};
        btn_tab[4] = '{x: 411, y: 334, enter: 1'b0};
        btn_tab[5] = '{x: 612, y: 400, enter: 1'b0};
        btn_tab[6] = '{x: 500, y: 333, enter: 1'b0};
        btn_tab[7] = '{x: 500, y: 434, enter: 1'b0};
        btn_tab[8] = '{x: 611, y: 334, enter: 1'b1};
        btn_tab[9] = '{x: 4000, y: 4000, enter: 1'b0};

        // Idle after reset: nothing moves and no respawn fires.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check("idle_respawns", 64'(resp_cnt), 64'd0);
        check("idle_bug_x", 64'(bus.bug_x), 64'd480);
        check("idle_bug_y", 64'(bus.bug_y), 64'd352);

        // Button edges, one click from a fresh START each.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            step(0, 0, 0, 0);
            step(1, btn_tab[i].x, btn_tab[i].y, 0);
            check("btn_screen", 64'(bus.screen), btn_tab[i].enter ? 64'd1 : 64'd0);
            check("btn_respawn", 64'(bus.bug_respawn), 64'(btn_tab[i].enter));
            step(0, 0, 0, 0);
            check("btn_respawn_once", 64'(bus.bug_respawn), 64'd0);
        end

        // Countdown with no hits.
        do_reset();
        step(1, 412, 433, 0);
        for (int i = 1; i <= 3 * CLK_HZ; i++) begin
            step(0, 0, 0, 0);
            if (i == CLK_HZ - 1)     check("cd_3", 64'(bus.seconds_left), 64'd3);
            if (i == CLK_HZ)         check("cd_2", 64'(bus.seconds_left), 64'd2);
            if (i == 2 * CLK_HZ)     check("cd_1", 64'(bus.seconds_left), 64'd1);
            if (i == 3 * CLK_HZ - 1) check("cd_still_play", 64'(bus.screen), 64'd1);
        end
        check("cd_0", 64'(bus.seconds_left), 64'd0);
        check("cd_over", 64'(bus.screen), 64'd2);
        check("cd_inactive", 64'(bus.game_active), 64'd0);

        // 105 hits: score saturates, every hit respawns inside the field.
        do_reset();
        enter_play();
        resp_cnt  = 0;
        bad_range = 0;
        for (int i = 0; i < 105; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        check("sat_score", 64'(bus.score), 64'd99);
        check("sat_respawns", 64'(resp_cnt), 64'd105);
        check("sat_range", 64'(bad_range), 64'd0);
        check("sat_play", 64'(bus.screen), 64'd1);

        // Hit on the final tick: counted, respawned, then OVER.
        do_reset();
        enter_play();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        begin
            int guard;
            guard = 0;
            while (!((m_presc == CLK_HZ - 1) && (m_sec == 1)) && (guard < 4 * CLK_HZ)) begin
                step(0, 0, 0, 0);
                guard++;
            end
            check("final_tick_found", 64'(guard < 4 * CLK_HZ), 64'd1);
        end
        step(0, 0, 0, 1);
        check("final_score", 64'(bus.score), 64'd4);
        check("final_respawn", 64'(bus.bug_respawn), 64'd1);
        check("final_over", 64'(bus.screen), 64'd2);
        step(0, 0, 0, 1);
        check("over_hit_ignored", 64'(bus.bug_respawn), 64'd0);
        step(1, 0, 0, 0);
        check("over_click_start", 64'(bus.screen), 64'd0);
        check("over_reload", 64'(bus.seconds_left), 64'd3);
        check("over_score_held", 64'(bus.score), 64'd4);

        // Asynchronous reset in the middle of a game.
        do_reset();
        enter_play();
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        while (m_sec != 2) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("pre_rst_score", 64'(bus.score), 64'd8);
        check("pre_rst_sec", 64'(bus.seconds_left), 64'd2);
        @(posedge pclk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge pclk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("post_rst_score", 64'(bus.score), 64'd0);

        // Randomized play, clicks biased toward the button.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit ml;
            bit h;
            int x;
            int y;
            ml = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 3) == 0);
            x  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(380, 640)) : int'($urandom_range(0, 4095));
            y  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(300, 460)) : int'($urandom_range(0, 4095));
            step(ml, x, y, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
